// File: rtl/riscv_mem_pkg.sv
// ----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types and constants for the data-memory responder slice.
//   state_t    : responder FSM state (IDLE / BUSY / RESP), 2 bits
//   LAT_CNT_W  : width of the access-latency down-counter
//   BE_ALL     : all four byte lanes enabled
//   clog2()    : word-index width for a given RAM depth
// ----------------------------------------------------------------------------
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LAT_CNT_W = 4;

  localparam logic [3:0] BE_ALL = 4'hF;

  // Ceiling log2; used at elaboration time to size the word index.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// ----------------------------------------------------------------------------
// dmem_responder_ram
// Synchronous single-port word RAM with per-byte write strobes and a
// registered read port. The read register only updates when re is high, so
// it holds the last loaded word for as long as the responder needs it.
//   clk    : clock
//   we     : write enable (lanes further gated by be)
//   be     : byte-lane write strobes, lane i = wdata[8i+7:8i]
//   re     : read enable, captures mem[addr] into rdata
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data
// ----------------------------------------------------------------------------
import riscv_mem_pkg::*;

module dmem_responder_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset; clearing a RAM array would turn it into
  // flops, and the control path alone decides whether its contents matter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the load/store port: accepts one word request
// over req_valid/req_ready, waits LATENCY cycles, then presents one response
// over rsp_valid/rsp_ready. Stores commit at the accept edge.
//   clk        : clock
//   rst        : asynchronous active-low reset (control path only)
//   req_valid  : request present          req_ready : responder idle
//   req_wr     : 1 = store, 0 = load      req_addr  : byte address
//   req_wdata  : store data               req_be    : store byte enables
//   rsp_valid  : response present         rsp_ready : initiator takes it
//   rsp_rdata  : load data, 0 for stores  rsp_err   : request faulted
// Build option: DMEM_RESPONDER_ERR_EN flags misaligned and out-of-range
// requests; without it the low address bits are ignored and the word index
// wraps modulo DEPTH_WORDS.
// ----------------------------------------------------------------------------
import riscv_mem_pkg::*;

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = clog2(DEPTH_WORDS);

  state_t               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 load_ok_q;  // in-flight request is a non-faulting load
  logic                 err_q;
  logic                 accept;
  logic                 fault;
  logic [31:0]          ram_rdata;

  assign accept = req_valid && req_ready;

`ifdef DMEM_RESPONDER_ERR_EN
  assign fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign fault            = 1'b0;
`endif

  dmem_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept && req_wr && !fault),
    .be    (req_be),
    .re    (accept && !req_wr && !fault),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  // State register, latency counter and response attributes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      load_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        load_ok_q <= !req_wr && !fault;
        err_q     <= fault;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Read data is masked to 0 outside a load response so stores,
  // faults and reset all present zero without resetting the RAM register.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = (state_q == RESP && load_ok_q) ? ram_rdata : 32'd0;
    rsp_err   = (state_q == RESP) && err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. Instance 0 uses LATENCY=2 and runs
// the vector table plus backpressure and mid-operation reset sequences;
// instances 1 and 2 use LATENCY=1 and LATENCY=15 for the latency sweep.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
import riscv_mem_pkg::*;

module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wr    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(15)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wr(req_wr[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int N_VEC = 13;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction on instance d with rsp_ready held high. Returns the
  // measured latency: posedges counted from the accept edge (inclusive) until
  // rsp_valid is seen.
  task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output int lat, output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[d]) check("req_ready_timeout", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] held;
    logic        seen;
    int          n;

    // Directed vectors for instance 0 (LATENCY=2).
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, BE_ALL, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0,   32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'h1,   32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'h0,   32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0,   32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h10,   32'h0,        4'h0,   32'hDEADBEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'h20,   32'h11223344, BE_ALL, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'hA,   32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h20,   32'h0,        4'h0,   32'hAA22CC44, 1'b0};
    vecs[9]  = '{1'b1, 32'h0,    32'hCAFEF00D, BE_ALL, 32'h0,        1'b0};
`ifdef DMEM_RESPONDER_ERR_EN
    vecs[10] = '{1'b1, 32'h1000, 32'h12345678, BE_ALL, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h0,    32'h0,        4'h0,   32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b0, 32'h13,   32'h0,        4'h0,   32'h0,        1'b1};
`else
    vecs[10] = '{1'b1, 32'h1000, 32'h12345678, BE_ALL, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h0,    32'h0,        4'h0,   32'h12345678, 1'b0};
    vecs[12] = '{1'b0, 32'h13,   32'h0,        4'h0,   32'hDEADBEAA, 1'b0};
`endif

    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0;
      req_wr[d]    = 1'b0;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
      req_be[d]    = 4'h0;
      rsp_ready[d] = 1'b1;
    end

    // Reset state.
    #1;
    check("reset_req_ready", 32'(req_ready[0]), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("reset_rsp_rdata", rsp_rdata[0], 32'd0);
    check("reset_rsp_err",   32'(rsp_err[0]),   32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Vector table.
    for (int i = 0; i < N_VEC; i++) begin
      txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rd, er);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Response backpressure: hold a load response for 5 cycles while a
    // competing store is presented; it must not be accepted.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b0;
    req_addr[0]  = 32'h10;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    held = rsp_rdata[0];
    check("bp_first_rdata", held, 32'hDEADBEAA);
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b1;
    req_wdata[0] = 32'h0;
    req_be[0]    = BE_ALL;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp%0d_rdata", c), rsp_rdata[0], 32'hDEADBEAA);
      check($sformatf("bp%0d_req_ready", c), 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("bp_release_req_ready", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("bp_store_not_taken", rd, 32'hDEADBEAA);

    // Reset mid-operation: a committed store survives, an in-flight load is
    // dropped without a response.
    txn(0, 1'b1, 32'h40, 32'h5A5A5A5A, BE_ALL, lat, rd, er);
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b0;
    req_addr[0]  = 32'h40;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("busy_req_ready", 32'(req_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    check("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) seen = 1'b1;
    end
    check("midrst_no_response", 32'(seen), 32'd0);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er);
    check("midrst_store_kept", rd, 32'h5A5A5A5A);

    // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
    txn(1, 1'b1, 32'h8, 32'h0BADCAFE, BE_ALL, lat, rd, er);
    check("lat1_store_latency", 32'(lat), 32'd1);
    check("lat1_store_rdata", rd, 32'd0);
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, lat, rd, er);
    check("lat1_load_latency", 32'(lat), 32'd1);
    check("lat1_load_rdata", rd, 32'h0BADCAFE);
    txn(2, 1'b1, 32'h8, 32'h76543210, BE_ALL, lat, rd, er);
    check("lat15_store_latency", 32'(lat), 32'd15);
    txn(2, 1'b0, 32'h8, 32'h0, 4'h0, lat, rd, er);
    check("lat15_load_latency", 32'(lat), 32'd15);
    check("lat15_load_rdata", rd, 32'h76543210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
